// File: rtl/pipelined_csel_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshakes.
// Stage 1 registers both per-slice candidates; stage 2 resolves the carry chain and flags.
module pipelined_csel_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   // WIDTH must be a whole multiple of BLOCK.
   localparam int NBLK = WIDTH / BLOCK;

   logic [WIDTH-1:0]           bx;
   logic                       c0;
   logic [NBLK-1:0][BLOCK:0]   cand0_new, cand1_new;

   logic                       s2_adv, s1_adv, s1_load, s2_load;

   logic                       s1_valid_d, s1_valid_q;
   logic [NBLK-1:0][BLOCK:0]   cand0_d, cand0_q, cand1_d, cand1_q;
   logic                       c0_d, c0_q, a_msb_d, a_msb_q, bx_msb_d, bx_msb_q;

   logic [WIDTH-1:0]           sum_sel;
   logic                       cout_sel, ovf_sel, zero_sel;

   logic                       out_valid_d, out_valid_q;
   logic [WIDTH-1:0]           sum_d, sum_q;
   logic                       cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

   always_comb begin
      bx = sub ? ~b : b;
      c0 = sub ? 1'b1 : cin;
      cand0_new = '0;
      cand1_new = '0;
      for (int k = 0; k < NBLK; k++) begin
         cand0_new[k] = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]};
         cand1_new[k] = cand0_new[k] + (BLOCK+1)'(1);
      end
   end

   // An empty output stage accepts from stage 1 even while out_ready is low.
   always_comb begin
      s2_adv   = !out_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      s1_load  = s1_adv && in_valid;
      s2_load  = s2_adv && s1_valid_q;
      in_ready = s1_adv;
   end

   always_comb begin
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      cand0_d    = s1_load ? cand0_new : cand0_q;
      cand1_d    = s1_load ? cand1_new : cand1_q;
      c0_d       = s1_load ? c0 : c0_q;
      a_msb_d    = s1_load ? a[WIDTH-1] : a_msb_q;
      bx_msb_d   = s1_load ? bx[WIDTH-1] : bx_msb_q;
   end

   always_comb begin
      logic             carry;
      logic [BLOCK:0]   sel;
      carry   = c0_q;
      sel     = '0;
      sum_sel = '0;
      for (int k = 0; k < NBLK; k++) begin
         sel = carry ? cand1_q[k] : cand0_q[k];
         sum_sel[k*BLOCK +: BLOCK] = sel[BLOCK-1:0];
         carry = sel[BLOCK];
      end
      cout_sel = carry;
      ovf_sel  = (a_msb_q == bx_msb_q) && (sum_sel[WIDTH-1] != a_msb_q);
      zero_sel = ~|sum_sel;
   end

   always_comb begin
      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
      sum_d       = s2_load ? sum_sel  : sum_q;
      cout_d      = s2_load ? cout_sel : cout_q;
      ovf_d       = s2_load ? ovf_sel  : ovf_q;
      zero_d      = s2_load ? zero_sel : zero_q;
   end

   // Stage-1 payload is meaningless while s1_valid is low, so it carries no reset.
   always_ff @(posedge clk) begin
      cand0_q  <= cand0_d;
      cand1_q  <= cand1_d;
      c0_q     <= c0_d;
      a_msb_q  <= a_msb_d;
      bx_msb_q <= bx_msb_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
